// File: rtl/bin2hex_enc_pkg.sv
// Shared constants, state encoding and character helpers for the Intel HEX encoder.
// Imported by the character output stage and the encoder FSM.
package bin2hex_enc_pkg;

    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] REC_DATA  = 8'h00;
    localparam logic [7:0] REC_EOF   = 8'h01;
    localparam int         EOF_CHARS = 13;

    typedef enum logic [3:0] {
        S_IDLE,
        S_COLON,
        S_LL,
        S_ADDR,
        S_TYPE,
        S_RDREQ,
        S_RDCAP,
        S_DATA,
        S_CKS,
        S_CR,
        S_LF,
        S_EOFREC,
        S_FIN
    } state_e;

    // One character request from the FSM: either a literal byte or a nibble to render.
    typedef struct packed {
        logic       vld;
        logic       lit;
        logic [7:0] chr;
        logic [3:0] nib;
    } char_req_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Fixed EOF record ":00000001FF" CR LF, indexed by character position.
    function automatic logic [7:0] eof_char(input logic [3:0] idx);
        logic [7:0] c;
        c = ASC_LF;
        case (idx)
            4'd0:                               c = ASC_COLON;
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: c = 8'h30;
            4'd7:                               c = hex_ascii(REC_EOF[7:4]);
            4'd8:                               c = hex_ascii(REC_EOF[3:0]);
            4'd9, 4'd10:                        c = 8'h46;
            4'd11:                              c = ASC_CR;
            default:                            c = ASC_LF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bin2hex_enc_if.sv
// Handshake and memory bus of the HEX encoder: control, memory read port, character stream.
interface bin2hex_enc_if;

    logic        START;
    logic [15:0] SA;
    logic [16:0] LEN;
    logic [15:0] AB;
    logic        RD;
    logic [7:0]  DB;
    logic [7:0]  DO;
    logic        DV;
    logic        RDY;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    modport slave (
        input  START, SA, LEN, DB, RDY,
        output AB, RD, DO, DV, BUSY, DONE, ERR
    );

    modport master (
        output START, SA, LEN, DB, RDY,
        input  AB, RD, DO, DV, BUSY, DONE, ERR
    );

endinterface

// File: rtl/bin2hex_enc_hex_char_out.sv
// Character output stage: renders a nibble or literal into the DO/DV holding register
// and runs the DV/RDY handshake; "taken" tells the FSM its request was accepted.
module hex_char_out
    import bin2hex_enc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  char_req_t  req,
    input  logic       rdy,
    output logic [7:0] char_o,
    output logic       vld_o,
    output logic       taken_o
);

    logic [7:0] char_q, char_d;
    logic       vld_q, vld_d;
    logic       free;

    // Register may be reloaded in the same cycle its current character transfers.
    assign free    = !vld_q || rdy;
    assign taken_o = req.vld && free;

    always_comb begin
        char_d = char_q;
        vld_d  = vld_q;
        if (taken_o) begin
            char_d = req.lit ? req.chr : hex_ascii(req.nib);
            vld_d  = 1'b1;
        end else if (vld_q && rdy) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_q <= 8'h00;
            vld_q  <= 1'b0;
        end else begin
            char_q <= char_d;
            vld_q  <= vld_d;
        end
    end

    assign char_o = char_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/bin2hex_enc.sv
// Binary-to-Intel-HEX encoder: reads a byte range from synchronous memory and streams
// data records followed by the EOF record as ASCII characters.
module bin2hex_enc
    import bin2hex_enc_pkg::*;
#(
    parameter int REC_LEN = 16
)
(
    input  logic         CLK,
    input  logic         CLRn,
    bin2hex_enc_if.slave bus
);

    localparam logic [16:0] REC_LEN_W = 17'(REC_LEN);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] rem_q, rem_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] rec_addr_q, rec_addr_d;
    logic [7:0]  rec_ll_q, rec_ll_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  cks_q, cks_d;
    logic        err_q, err_d;

    char_req_t   creq;
    logic        taken;
    logic        dv;
    logic [7:0]  do_w;

    logic [17:0] end_addr;
    logic [7:0]  ll_calc;
    logic [7:0]  field_byte;
    logic [3:0]  field_last;
    state_e      field_next;

    hex_char_out u_char_out (
        .clk     (CLK),
        .rst_n   (CLRn),
        .req     (creq),
        .rdy     (bus.RDY),
        .char_o  (do_w),
        .vld_o   (dv),
        .taken_o (taken)
    );

    always_comb begin
        end_addr = {2'b00, bus.SA} + {1'b0, bus.LEN};
        ll_calc  = (rem_q > REC_LEN_W) ? REC_LEN_W[7:0] : rem_q[7:0];
    end

    // Byte shown by the current hex field, its last nibble index and the follow-on state.
    always_comb begin
        field_byte = 8'h00;
        field_last = 4'd1;
        field_next = S_IDLE;
        case (state_q)
            S_LL:   begin field_byte = rec_ll_q; field_next = S_ADDR; end
            S_ADDR: begin
                field_byte = cnt_q[1] ? rec_addr_q[7:0] : rec_addr_q[15:8];
                field_last = 4'd3;
                field_next = S_TYPE;
            end
            S_TYPE: begin field_byte = REC_DATA; field_next = S_RDREQ; end
            S_DATA: begin
                field_byte = data_q;
                field_next = (byte_cnt_q == 8'd0) ? S_CKS : S_RDREQ;
            end
            S_CKS:  begin field_byte = 8'h00 - cks_q; field_next = S_CR; end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        addr_d     = addr_q;
        rec_addr_d = rec_addr_q;
        rec_ll_d   = rec_ll_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        cks_d      = cks_q;
        err_d      = 1'b0;
        creq       = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    if (end_addr > 18'd65536) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = bus.SA;
                        rem_d   = bus.LEN;
                        cnt_d   = 4'd0;
                        state_d = (bus.LEN == 17'd0) ? S_EOFREC : S_COLON;
                    end
                end
            end
            S_COLON: begin
                creq.vld = 1'b1;
                creq.lit = 1'b1;
                creq.chr = ASC_COLON;
                if (taken) begin
                    rec_ll_d   = ll_calc;
                    byte_cnt_d = ll_calc;
                    rec_addr_d = addr_q;
                    cks_d      = ll_calc + addr_q[15:8] + addr_q[7:0] + REC_DATA;
                    cnt_d      = 4'd0;
                    state_d    = S_LL;
                end
            end
            S_LL, S_ADDR, S_TYPE, S_DATA, S_CKS: begin
                creq.vld = 1'b1;
                creq.nib = cnt_q[0] ? field_byte[3:0] : field_byte[7:4];
                if (taken) begin
                    if (cnt_q == field_last) begin
                        cnt_d   = 4'd0;
                        state_d = field_next;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            S_RDREQ: state_d = S_RDCAP;
            S_RDCAP: begin
                data_d     = bus.DB;
                cks_d      = cks_q + bus.DB;
                addr_d     = addr_q + 16'd1;
                rem_d      = rem_q - 17'd1;
                byte_cnt_d = byte_cnt_q - 8'd1;
                state_d    = S_DATA;
            end
            S_CR: begin
                creq.vld = 1'b1;
                creq.lit = 1'b1;
                creq.chr = ASC_CR;
                if (taken) state_d = S_LF;
            end
            S_LF: begin
                creq.vld = 1'b1;
                creq.lit = 1'b1;
                creq.chr = ASC_LF;
                if (taken) begin
                    cnt_d   = 4'd0;
                    state_d = (rem_q == 17'd0) ? S_EOFREC : S_COLON;
                end
            end
            S_EOFREC: begin
                creq.vld = 1'b1;
                creq.lit = 1'b1;
                creq.chr = eof_char(cnt_q);
                if (taken) begin
                    if (cnt_q == 4'(EOF_CHARS - 1)) begin
                        cnt_d   = 4'd0;
                        state_d = S_FIN;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            // Hold until the final LF has left the output register.
            S_FIN: if (!dv) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            rem_q      <= 17'd0;
            addr_q     <= 16'd0;
            rec_addr_q <= 16'd0;
            rec_ll_q   <= 8'd0;
            byte_cnt_q <= 8'd0;
            data_q     <= 8'd0;
            cks_q      <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            rec_addr_q <= rec_addr_d;
            rec_ll_q   <= rec_ll_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            cks_q      <= cks_d;
            err_q      <= err_d;
        end
    end

    assign bus.AB   = addr_q;
    assign bus.RD   = (state_q != S_RDREQ);
    assign bus.DO   = do_w;
    assign bus.DV   = dv;
    assign bus.BUSY = (state_q != S_IDLE);
    assign bus.DONE = (state_q == S_FIN) && !dv;
    assign bus.ERR  = err_q;

endmodule

// File: tb/tb_bin2hex_enc.sv
// Scoreboard bench for bin2hex_enc: expected characters and read addresses are queued
// from a reference model; a monitor pops and compares on every transfer and read strobe.
module tb_bin2hex_enc;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    bin2hex_enc_if bif();

    bin2hex_enc #(.REC_LEN(16)) dut (
        .CLK  (clk),
        .CLRn (clrn),
        .bus  (bif)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    logic [7:0] exp_q[$];
    int         rd_q[$];
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         dv_cnt = 0;
    bit         rdy_rand = 1'b0;
    bit         stall_prev = 1'b0;
    logic [7:0] stall_do = 8'h00;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Synchronous memory: data appears on the edge after RD low.
    always @(posedge clk) if (!bif.RD) bif.DB <= mem[bif.AB];

    initial begin
        int stall_left;
        stall_left = 0;
        bif.RDY = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (!rdy_rand) bif.RDY = 1'b1;
            else if (stall_left > 0) begin bif.RDY = 1'b0; stall_left--; end
            else if ($urandom_range(0, 7) == 0) begin bif.RDY = 1'b0; stall_left = 4; end
            else bif.RDY = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: everything sampled mid-cycle, describing the upcoming rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!clrn) stall_prev = 1'b0;
            else begin
                if (stall_prev) begin
                    chk("hold_dv", int'(bif.DV), 1);
                    chk("hold_do", int'(bif.DO), int'(stall_do));
                end
                stall_prev = bif.DV && !bif.RDY;
                stall_do   = bif.DO;
                if (bif.DV && bif.RDY) begin
                    chk("char_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) chk("char", int'(bif.DO), int'(exp_q.pop_front()));
                end
                if (!bif.RD) begin
                    chk("rd_expected", int'(rd_q.size() > 0), 1);
                    if (rd_q.size() > 0) chk("rd_addr", int'(bif.AB), rd_q.pop_front());
                end
                if (bif.DONE) begin
                    done_cnt++;
                    chk("done_chars_left", exp_q.size(), 0);
                    chk("done_dv", int'(bif.DV), 0);
                end
                if (bif.ERR) err_cnt++;
                if (bif.DV) dv_cnt++;
            end
        end
    end

    function automatic logic [7:0] hexc(input int n);
        return 8'(n < 10 ? 48 + n : 55 + n);
    endfunction

    task automatic push_hex(input int v);
        exp_q.push_back(hexc((v >> 4) & 15));
        exp_q.push_back(hexc(v & 15));
    endtask

    // Reference model: builds the whole file from the record rules.
    task automatic push_file(input int sa, input int len);
        int    addr, rem, ll, sum, b;
        string eofs;
        addr = sa;
        rem  = len;
        while (rem > 0) begin
            ll  = (rem < 16) ? rem : 16;
            sum = ll + (addr >> 8) + (addr & 255);
            exp_q.push_back(8'h3A);
            push_hex(ll);
            push_hex((addr >> 8) & 255);
            push_hex(addr & 255);
            push_hex(0);
            for (int i = 0; i < ll; i++) begin
                b = int'(mem[addr + i]);
                push_hex(b);
                rd_q.push_back(addr + i);
                sum += b;
            end
            push_hex((256 - (sum % 256)) % 256);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            addr += ll;
            rem  -= ll;
        end
        eofs = ":00000001FF\r\n";
        for (int i = 0; i < eofs.len(); i++) exp_q.push_back(eofs[i]);
    endtask

    task automatic start_conv(input int sa, input int len);
        @(posedge clk); #1;
        bif.SA    = 16'(sa);
        bif.LEN   = 17'(len);
        bif.START = 1'b1;
        @(posedge clk); #1;
        bif.START = 1'b0;
    endtask

    // Runs one accepted conversion whose expectations are already queued.
    task automatic run_conv(input int sa, input int len);
        int d0, e0, n;
        d0 = done_cnt;
        e0 = err_cnt;
        start_conv(sa, len);
        chk("busy_after_start", int'(bif.BUSY), 1);
        @(posedge clk); #1;
        chk("first_dv", int'(bif.DV), 1);
        chk("first_colon", int'(bif.DO), 8'h3A);
        // A START while busy (even an out-of-range one) must be ignored.
        bif.SA = 16'hFFFF; bif.LEN = 17'd10; bif.START = 1'b1;
        @(posedge clk); #1;
        bif.START = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 20000) begin @(posedge clk); n++; end
        #1;
        chk("done_seen", int'(done_cnt != d0), 1);
        chk("busy_cleared", int'(bif.BUSY), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        chk("chars_left", exp_q.size(), 0);
        chk("reads_left", rd_q.size(), 0);
        chk("no_err_while_busy", err_cnt - e0, 0);
        exp_q.delete();
        rd_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ab"},   int'(bif.AB), 0);
        chk({tag, "_rd"},   int'(bif.RD), 1);
        chk({tag, "_do"},   int'(bif.DO), 0);
        chk({tag, "_dv"},   int'(bif.DV), 0);
        chk({tag, "_busy"}, int'(bif.BUSY), 0);
        chk({tag, "_done"}, int'(bif.DONE), 0);
        chk({tag, "_err"},  int'(bif.ERR), 0);
    endtask

    initial begin
        string s1;
        int    sa, len, e0, dv0, n;
        bif.START = 1'b0;
        bif.SA    = 16'h0;
        bif.LEN   = 17'h0;
        bif.DB    = 8'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        #3;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        clrn = 1'b1;

        // Fixed three-byte file against a literal expected stream.
        mem[16'h0100] = 8'h01; mem[16'h0101] = 8'h02; mem[16'h0102] = 8'h03;
        s1 = ":03010000010203F6\r\n:00000001FF\r\n";
        for (int i = 0; i < s1.len(); i++) exp_q.push_back(s1[i]);
        rd_q.push_back(16'h0100); rd_q.push_back(16'h0101); rd_q.push_back(16'h0102);
        run_conv(16'h0100, 3);

        // Same file with backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < s1.len(); i++) exp_q.push_back(s1[i]);
        rd_q.push_back(16'h0100); rd_q.push_back(16'h0101); rd_q.push_back(16'h0102);
        run_conv(16'h0100, 3);
        rdy_rand = 1'b0;

        // Empty range: EOF only.
        push_file(16'h1234, 0);
        run_conv(16'h1234, 0);

        // Two records, memory holds its own address.
        for (int i = 0; i < 20; i++) mem[i] = 8'(i);
        push_file(0, 20);
        run_conv(0, 20);

        // START coinciding with DONE is ignored.
        push_file(16'h0200, 0);
        start_conv(16'h0200, 0);
        n = 0;
        while (!bif.DONE && n < 200) begin @(negedge clk); n++; end
        chk("collide_done_seen", int'(bif.DONE), 1);
        bif.SA = 16'h0; bif.LEN = 17'd1; bif.START = 1'b1;
        @(posedge clk); #1;
        bif.START = 1'b0;
        dv0 = dv_cnt;
        repeat (5) @(posedge clk);
        #1;
        chk("collide_busy", int'(bif.BUSY), 0);
        chk("collide_no_dv", dv_cnt - dv0, 0);
        chk("collide_chars_left", exp_q.size(), 0);

        // Out-of-range starts are rejected; exact 64K end is accepted.
        e0  = err_cnt;
        dv0 = dv_cnt;
        @(posedge clk); #1;
        bif.SA = 16'hFFF0; bif.LEN = 17'h20; bif.START = 1'b1;
        @(posedge clk); #1;
        bif.START = 1'b0;
        chk("err_pulse", int'(bif.ERR), 1);
        chk("err_busy", int'(bif.BUSY), 0);
        @(posedge clk); #1;
        chk("err_one_cycle", int'(bif.ERR), 0);
        start_conv(16'hFFFF, 2);
        repeat (10) @(posedge clk);
        #1;
        chk("err_count", err_cnt - e0, 2);
        chk("err_no_dv", dv_cnt - dv0, 0);
        push_file(16'hFFC0, 16'h40);
        run_conv(16'hFFC0, 16'h40);

        // Reset in the middle of a data record, then a complete rerun.
        rdy_rand = 1'b1;
        push_file(16'h1000, 40);
        start_conv(16'h1000, 40);
        repeat (30) @(posedge clk);
        #1;
        clrn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        rd_q.delete();
        @(posedge clk); #1;
        clrn = 1'b1;
        push_file(16'h1000, 40);
        run_conv(16'h1000, 40);

        // Random ranges under random backpressure.
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(0, 50);
            sa  = $urandom_range(0, 65536 - len);
            push_file(sa, len);
            run_conv(sa, len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
